// File: rtl/ftdi_frame_packetizer.sv
// Frames multi-channel sample vectors into a byte-wide AXI-Stream for the FT232H writer.
// Build with FTDI_PACKETIZER_CHECKSUM_EN defined to append a two's-complement checksum byte.
module ftdi_frame_packetizer #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst,
  input  logic [SAMPLE_WIDTH*NUM_CHANNELS-1:0] s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  output logic [7:0]                           m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [7:0]                           seq_num,
  output logic                                 busy
);

  localparam int unsigned SampleBytes  = SAMPLE_WIDTH / 8;
  localparam int unsigned PayloadBytes = NUM_CHANNELS * SampleBytes;
  localparam int unsigned DataW        = SAMPLE_WIDTH * NUM_CHANNELS;
  localparam int unsigned IdxW         = (PayloadBytes > 1) ? $clog2(PayloadBytes) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(PayloadBytes - 1);

`ifdef FTDI_PACKETIZER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StSync, StSeq, StPayload, StChecksum} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSync, StSeq, StPayload} state_e;
`endif

  state_e            r_state;
  logic [DataW-1:0]  r_shadow;
  logic [7:0]        r_tdata;
  logic [7:0]        r_seq_num;
  logic [7:0]        r_frame_seq;
  logic [IdxW-1:0]   r_idx;
  logic              w_handshake;

`ifdef FTDI_PACKETIZER_CHECKSUM_EN
  logic [7:0]        r_acc;
  logic [7:0]        w_acc_next;
  // r_tdata always holds the byte being handshaken, so it is the next addend.
  assign w_acc_next = r_acc + r_tdata;
`endif

  assign s_axis_tready = (r_state == StIdle);
  assign m_axis_tvalid = (r_state != StIdle);
  assign busy          = (r_state != StIdle);
  assign m_axis_tdata  = r_tdata;
  assign seq_num       = r_seq_num;
  assign w_handshake   = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= StIdle;
      r_shadow    <= '0;
      r_tdata     <= 8'h00;
      r_seq_num   <= 8'h00;
      r_frame_seq <= 8'h00;
      r_idx       <= '0;
`ifdef FTDI_PACKETIZER_CHECKSUM_EN
      r_acc       <= 8'h00;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (s_axis_tvalid) begin
            r_shadow    <= s_axis_tdata;
            r_frame_seq <= r_seq_num;
            r_idx       <= '0;
`ifdef FTDI_PACKETIZER_CHECKSUM_EN
            r_acc       <= 8'h00;
`endif
            r_tdata     <= SYNC_BYTE;
            r_state     <= StSync;
          end
        end
        StSync: begin
          if (w_handshake) begin
            r_tdata <= r_frame_seq;
            r_state <= StSeq;
          end
        end
        StSeq: begin
          if (w_handshake) begin
`ifdef FTDI_PACKETIZER_CHECKSUM_EN
            r_acc    <= w_acc_next;
`endif
            // Shadow is consumed LSB-first by shifting, so byte idx is always at [7:0].
            r_tdata  <= r_shadow[7:0];
            r_shadow <= r_shadow >> 8;
            r_state  <= StPayload;
          end
        end
        StPayload: begin
          if (w_handshake) begin
`ifdef FTDI_PACKETIZER_CHECKSUM_EN
            r_acc <= w_acc_next;
`endif
            if (r_idx == LastIdx) begin
`ifdef FTDI_PACKETIZER_CHECKSUM_EN
              r_tdata   <= 8'h00 - w_acc_next;
              r_state   <= StChecksum;
`else
              r_tdata   <= 8'h00;
              r_seq_num <= r_seq_num + 8'd1;
              r_state   <= StIdle;
`endif
            end else begin
              r_idx    <= r_idx + 1'b1;
              r_tdata  <= r_shadow[7:0];
              r_shadow <= r_shadow >> 8;
            end
          end
        end
`ifdef FTDI_PACKETIZER_CHECKSUM_EN
        StChecksum: begin
          if (w_handshake) begin
            r_tdata   <= 8'h00;
            r_seq_num <= r_seq_num + 8'd1;
            r_state   <= StIdle;
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_frame_packetizer.sv
// Self-checking bench for ftdi_frame_packetizer; honours FTDI_PACKETIZER_CHECKSUM_EN when defined.
module tb_ftdi_frame_packetizer;

`ifdef FTDI_PACKETIZER_CHECKSUM_EN
  localparam int Cks = 1;
`else
  localparam int Cks = 0;
`endif
  localparam int Pb0 = 4;
  localparam int F0  = 2 + Pb0 + Cks;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [7:0]  seq_num;
  logic        busy;

  logic [7:0]  s1_tdata = '0;
  logic        s1_tvalid = 1'b0;
  logic        s1_tready;
  logic [7:0]  m1_tdata;
  logic        m1_tvalid;
  logic        m1_tready = 1'b1;
  logic [7:0]  seq1;
  logic        busy1;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  seq_model;
  logic [31:0] d;
  logic [31:0] d2;
  logic [7:0]  d1;
  int unsigned last_acc;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  ftdi_frame_packetizer dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .seq_num       (seq_num),
    .busy          (busy)
  );

  ftdi_frame_packetizer #(
    .SAMPLE_WIDTH (8),
    .NUM_CHANNELS (1)
  ) dut1 (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .s_axis_tdata  (s1_tdata),
    .s_axis_tvalid (s1_tvalid),
    .s_axis_tready (s1_tready),
    .m_axis_tdata  (m1_tdata),
    .m_axis_tvalid (m1_tvalid),
    .m_axis_tready (m1_tready),
    .seq_num       (seq1),
    .busy          (busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference frame: sync, seq, payload bytes LSB-first, then the byte that zeroes the sum.
  function automatic void build_frame(input logic [31:0] data, input int pb, input logic [7:0] seq);
    int sum;
    logic [7:0] by;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    sum = int'(seq);
    for (int b = 0; b < pb; b++) begin
      by = data[8*b +: 8];
      exp_q.push_back(by);
      sum += int'(by);
    end
    if (Cks == 1) exp_q.push_back(8'((256 - (sum % 256)) % 256));
  endfunction

  task automatic apply_reset();
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Drives one vector into dut and follows the bytes in exp_q, optionally with random stalls.
  task automatic run_frame(input logic [31:0] data, input bit stall);
    int i;
    int n;
    bit rdy;
    check("idle_before_accept", s_tready, 1);
    s_tdata  = data;
    s_tvalid = 1'b1;
    @(negedge sys_clk);
    s_tvalid = 1'b0;
    s_tdata  = $urandom;
    i = 0;
    n = 0;
    while (i < exp_q.size() && n < 400) begin
      check("tvalid", m_tvalid, 1);
      check("tdata", m_tdata, exp_q[i]);
      check("s_tready_busy", s_tready, 0);
      rdy = stall ? 1'($urandom_range(1, 0)) : 1'b1;
      m_tready = rdy;
      @(negedge sys_clk);
      n++;
      if (rdy) i++;
    end
    check("frame_done", i, exp_q.size());
    check("tvalid_after", m_tvalid, 0);
    check("busy_after", busy, 0);
    seq_model++;
    check("seq_num_after", seq_num, seq_model);
    m_tready = 1'b1;
  endtask

  initial begin
    apply_reset();
    check("rst_s_tready", s_tready, 1);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_seq_num", seq_num, 0);
    check("rst_busy", busy, 0);
    check("rst_dut1_tvalid", m1_tvalid, 0);

    // Directed vector with hand-computed bytes.
    seq_model = 8'h00;
    exp_q = '{8'hA5, 8'h00, 8'hCD, 8'hAB, 8'h34, 8'h12};
    if (Cks == 1) exp_q.push_back(8'h42);
    run_frame(32'h1234_ABCD, 1'b0);

    // Single 8-bit channel: fourth frame carries FF at sequence 3.
    for (int k = 0; k < 4; k++) begin
      d1 = (k == 3) ? 8'hFF : 8'($urandom);
      check("dut1_idle", s1_tready, 1);
      if (k == 3) begin
        exp_q = '{8'hA5, 8'h03, 8'hFF};
        if (Cks == 1) exp_q.push_back(8'hFE);
      end else begin
        build_frame({24'h0, d1}, 1, 8'(k));
      end
      s1_tdata  = d1;
      s1_tvalid = 1'b1;
      @(negedge sys_clk);
      s1_tvalid = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        check("dut1_tvalid", m1_tvalid, 1);
        check("dut1_tdata", m1_tdata, exp_q[i]);
        @(negedge sys_clk);
      end
      check("dut1_tvalid_after", m1_tvalid, 0);
      check("dut1_seq", seq1, 32'(k + 1));
    end

    // Random data with random back-pressure.
    repeat (100) begin
      d = $urandom;
      build_frame(d, Pb0, seq_model);
      run_frame(d, 1'b1);
    end

    // Reset while payload byte idx 2 is on the bus.
    d = $urandom;
    build_frame(d, Pb0, seq_model);
    check("rstmid_idle", s_tready, 1);
    s_tdata  = d;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    @(negedge sys_clk);
    s_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rstmid_tdata", m_tdata, exp_q[i]);
      if (i < 4) @(negedge sys_clk);
    end
    d2 = $urandom;
    s_tdata = d2;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("rstmid_tvalid", m_tvalid, 0);
    check("rstmid_seq", seq_num, 0);
    check("rstmid_s_tready", s_tready, 1);
    seq_model = 8'h00;
    build_frame(d2, Pb0, seq_model);
    run_frame(d2, 1'b0);

    // Back-to-back frames with tvalid held high, across the sequence wrap.
    apply_reset();
    seq_model = 8'h00;
    m_tready  = 1'b1;
    s_tvalid  = 1'b1;
    last_acc  = 0;
    for (int f = 0; f < 257; f++) begin
      check("b2b_idle", s_tready, 1);
      d = $urandom;
      s_tdata = d;
      build_frame(d, Pb0, seq_model);
      if (f > 0) check("b2b_period", cyc - last_acc, 32'(F0 + 1));
      last_acc = cyc;
      @(negedge sys_clk);
      for (int i = 0; i < exp_q.size(); i++) begin
        check("b2b_s_tready", s_tready, 0);
        check("b2b_tvalid", m_tvalid, 1);
        check("b2b_tdata", m_tdata, exp_q[i]);
        @(negedge sys_clk);
      end
      seq_model++;
    end
    s_tvalid = 1'b0;
    check("b2b_seq_wrap", seq_num, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ftdi_frame_packetizer.md
# ftdi_frame_packetizer

Packs multi-channel sample words from the acquisition path into framed byte streams for the FT232H transmit path. Sits directly upstream of the FTDI sync-FIFO writer in the `sys_clk` domain. Its byte-wide AXI-Stream master drives that block's `tdata`/`tvalid`/`tready` input. Each captured sample vector becomes one frame: sync byte, sequence number, little-endian payload, and an optional checksum.

## Interface
- `SAMPLE_WIDTH`, 16: bits per channel sample; multiple of 8, range 8–32.
- `NUM_CHANNELS`, 2: channels per sample vector, range 1–8.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.

Ports:
- `sys_clk`  in  1  single clock for all logic.
- `sys_rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  `SAMPLE_WIDTH*NUM_CHANNELS`  sample vector; channel k occupies bits `[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]`.
- `s_axis_tvalid`  in  1  sample vector valid.
- `s_axis_tready`  out  1  packetizer accepts a vector.
- `m_axis_tdata`  out  8  frame byte toward the FTDI writer.
- `m_axis_tvalid`  out  1  frame byte valid.
- `m_axis_tready`  in  1  FTDI writer accepts the byte.
- `seq_num`  out  8  sequence number of the next frame to be emitted.
- `busy`  out  1  a frame is in progress (state is not IDLE).

## Operation
- Derived constants: `SAMPLE_BYTES = SAMPLE_WIDTH/8` and `PAYLOAD_BYTES = NUM_CHANNELS*SAMPLE_BYTES`.
- States and transitions:
  - **IDLE**: `s_axis_tready=1`. On `s_axis_tvalid`, latch `s_axis_tdata` into a shadow register and latch `seq_num` into the frame sequence register. Clear the checksum accumulator and byte index, then go to SYNC.
  - **SYNC**: emit `SYNC_BYTE`. On handshake, go to SEQ.
  - **SEQ**: emit the latched sequence number and add it to the accumulator. On handshake, go to PAYLOAD.
  - **PAYLOAD**: emit shadow byte `[idx*8 +: 8]`, where `idx` runs 0 to `PAYLOAD_BYTES-1`. This gives channel 0 first, least-significant byte first. Add each byte to the accumulator on its handshake. After the handshake at the last `idx`, go to CHECKSUM if enabled, otherwise finish the frame.
  - **CHECKSUM**: emit the two's complement of the 8-bit accumulator. On handshake, finish the frame.
  - **Finish the frame**: increment `seq_num` (modulo 256, so 255 wraps to 0) and go to IDLE.
- `s_axis_tready` is 0 in every state except IDLE. `m_axis_tvalid` is 1 in every state except IDLE.
- A handshake is `m_axis_tvalid & m_axis_tready`. With `m_axis_tvalid=1` and `m_axis_tready=0`, `m_axis_tdata` holds stable and the state does not advance.
- Shadow register changes only on an IDLE-state accept, so upstream may change `s_axis_tdata` freely mid-frame.
- Accumulator is an 8-bit sum, modulo 256, of the sequence byte and all payload bytes. The sync byte is excluded.
- `m_axis_tdata` is registered or decoded from registered state only. There is no combinational path from `m_axis_tready` to `s_axis_tready`.

## Timing
- Reset values: state IDLE, `s_axis_tready=1`, `m_axis_tvalid=0`, `m_axis_tdata=8'h00`, `seq_num=0`, `busy=0`, accumulator 0, index 0.
- Latency: accept in cycle N puts the sync byte on `m_axis_tvalid` in cycle N+1.
- Frame length: `F = 2 + PAYLOAD_BYTES + CKS`, where CKS is 1 with the checksum enabled and 0 without.
- With `m_axis_tready` held at 1, a frame occupies cycles N+1 to N+F. IDLE is re-entered at N+F+1, so the next accept is possible at N+F+1 and the minimum period is F+1 cycles per frame.
- Back-pressure: stalls of any length, at any byte, only delay the frame. No bytes are dropped or duplicated.
- Reset mid-frame: the partial frame is abandoned, `m_axis_tvalid` falls in the cycle after `sys_rst` is sampled high, and `seq_num` returns to 0.
- Simultaneous `s_axis_tvalid` with the final-byte handshake: the vector is not accepted until the following IDLE cycle.

## Configuration
- Macro: `FTDI_PACKETIZER_CHECKSUM_EN`.
- Defined: the CHECKSUM state and accumulator are present, and each frame ends with a checksum byte such that the sequence byte plus all payload bytes plus the checksum byte equal 0 modulo 256.
- Undefined: no accumulator or CHECKSUM state is built, frames end after the last payload byte, and F = 2 + `PAYLOAD_BYTES`.

## Test plan
- Defaults, checksum on, `m_axis_tready=1`, one vector `32'h1234_ABCD` after reset -> bytes A5, 00, CD, AB, 34, 12, 42 on consecutive cycles, then `seq_num=1`.
- Same vector with the checksum macro undefined -> A5, 00, CD, AB, 34, 12, then `m_axis_tvalid=0`.
- Random `m_axis_tready` stalls (about 50% duty) across 100 random frames -> byte stream identical to the no-stall model, and `m_axis_tdata` stable during every stall.
- 257 back-to-back frames with `s_axis_tvalid` held at 1 -> sequence bytes 00 through FF then 00, every accept F+1 cycles apart, and `s_axis_tready=0` throughout each frame.
- `sys_rst` pulsed during the PAYLOAD byte at idx 2, with `s_axis_tdata` changed mid-frame -> `m_axis_tvalid` low next cycle, `seq_num=0`, and the next frame starts with A5, 00 and carries the newly accepted data.
- `NUM_CHANNELS=1`, `SAMPLE_WIDTH=8`, data 8'hFF at `seq_num` 3 -> bytes A5, 03, FF, FE.
